// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract: IDLE -> ALIGN -> ADD -> NORM -> DONE.
// Optional FP_SPECIALS_EN decodes exp==255 operands as inf/NaN; otherwise they are ordinary finite values.

module right_shift (
  input  logic [23:0] din,
  input  logic [4:0]  shamt,
  output logic [23:0] dout
);
  always_comb begin
    dout = din;
    for (int unsigned i = 0; i < 5; i++)
      if (shamt[i]) dout = dout >> (1 << i);
  end
endmodule

module left_shift (
  input  logic [24:0] din,
  input  logic [4:0]  shamt,
  output logic [24:0] dout
);
  always_comb begin
    dout = din;
    for (int unsigned i = 0; i < 5; i++)
      if (shamt[i]) dout = dout << (1 << i);
  end
endmodule

module fp_addsub_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] a_r, b_r;
  logic [23:0] ml_r, ms_r;
  logic [7:0]  exp_r;
  logic        sign_r, sub_r;
  logic [24:0] sum_r;
  logic [31:0] result_r;
`ifdef FP_SPECIALS_EN
  logic        spec_r;
  logic [31:0] spec_val_r;
  logic        spec_hit;
  logic [31:0] spec_val;
`endif

  // ALIGN: order by magnitude (ties keep A as the larger) and align the smaller mantissa
  logic        a_big;
  logic [31:0] l_op, s_op;
  logic [23:0] m_l, m_s_raw, m_s_sh, m_s_al;
  logic [7:0]  d;

  always_comb begin
    a_big   = (a_r[30:0] >= b_r[30:0]);
    l_op    = a_big ? a_r : b_r;
    s_op    = a_big ? b_r : a_r;
    m_l     = (l_op[30:23] == 8'd0) ? '0 : {1'b1, l_op[22:0]};
    m_s_raw = (s_op[30:23] == 8'd0) ? '0 : {1'b1, s_op[22:0]};
    d       = l_op[30:23] - s_op[30:23];
  end

  right_shift u_rsh (.din(m_s_raw), .shamt(d[4:0]), .dout(m_s_sh));

  assign m_s_al = (d >= 8'd24) ? '0 : m_s_sh;

`ifdef FP_SPECIALS_EN
  logic a_nan, b_nan, a_inf, b_inf;
  always_comb begin
    a_nan    = (a_r[30:23] == 8'hFF) && (a_r[22:0] != '0);
    b_nan    = (b_r[30:23] == 8'hFF) && (b_r[22:0] != '0);
    a_inf    = (a_r[30:23] == 8'hFF) && (a_r[22:0] == '0);
    b_inf    = (b_r[30:23] == 8'hFF) && (b_r[22:0] == '0);
    spec_hit = a_nan || b_nan || a_inf || b_inf;
    spec_val = '0;
    if (a_nan || b_nan)      spec_val = 32'h7FC0_0000;
    else if (a_inf && b_inf) spec_val = (a_r[31] != b_r[31]) ? 32'h7FC0_0000 : a_r;
    else if (a_inf)          spec_val = a_r;
    else if (b_inf)          spec_val = b_r;
  end
`endif

  // NORM: leading-zero count of sum[23:0], then left shift into place
  logic [4:0]  z;
  logic        hit;
  logic [24:0] lsh;
  logic [1:0]  unused_lsh;
  logic [8:0]  e_inc;
  logic [7:0]  e_sub;
  logic [31:0] norm_res;

  always_comb begin
    z   = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < 24; i++)
      if (!hit && sum_r[23 - i]) begin
        z   = 5'(i);
        hit = 1'b1;
      end
  end

  left_shift u_lsh (.din(sum_r), .shamt(z), .dout(lsh));

  assign unused_lsh = lsh[24:23];

  always_comb begin
    e_inc    = {1'b0, exp_r} + 9'd1;
    e_sub    = exp_r - {3'b0, z};
    norm_res = '0;
    if (sum_r == '0)
      norm_res = '0;
    else if (sum_r[24])
      norm_res = (e_inc >= 9'd255) ? {sign_r, 8'hFF, 23'b0} : {sign_r, e_inc[7:0], sum_r[23:1]};
    else if (exp_r <= {3'b0, z})
      norm_res = {sign_r, 31'b0};
    else if (e_sub == 8'hFF)
      norm_res = {sign_r, 8'hFF, 23'b0};
    else
      norm_res = {sign_r, e_sub, lsh[22:0]};
`ifdef FP_SPECIALS_EN
    if (spec_r) norm_res = spec_val_r;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = ALIGN;
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      ml_r       <= '0;
      ms_r       <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      sub_r      <= 1'b0;
      sum_r      <= '0;
      result_r   <= '0;
`ifdef FP_SPECIALS_EN
      spec_r     <= 1'b0;
      spec_val_r <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= {b[31] ^ op, b[30:0]};
        end
        ALIGN: begin
          ml_r   <= m_l;
          ms_r   <= m_s_al;
          exp_r  <= l_op[30:23];
          sign_r <= l_op[31];
          sub_r  <= l_op[31] ^ s_op[31];
`ifdef FP_SPECIALS_EN
          spec_r     <= spec_hit;
          spec_val_r <= spec_val;
`endif
        end
        ADD:  sum_r <= sub_r ? ({1'b0, ml_r} - {1'b0, ms_r}) : ({1'b0, ml_r} + {1'b0, ms_r});
        NORM: result_r <= norm_res;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_r;
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed plan vectors plus randomized operands vs a truncating FP model.

module tb_fp_addsub_seq;
  logic        clk, rst_n, in_valid, in_ready, op, out_valid, out_ready, busy;
  logic [31:0] a, b, result;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb[$];
  bit          rand_rdy = 1'b0;
  logic [31:0] exp_v;

  fp_addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endfunction

  // Reference: unpack, order, align, add, renormalise with plain integer arithmetic
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y0, input logic opx);
    logic [31:0] y, l, s;
    int          el, es, dd, e;
    longint      ml, ms, sum;
    logic        sg;
    y = {y0[31] ^ opx, y0[30:0]};
`ifdef FP_SPECIALS_EN
    begin
      bit xn, yn, xi, yi;
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (xn || yn) return 32'h7FC0_0000;
      if (xi && yi) return (x[31] == y[31]) ? x : 32'h7FC0_0000;
      if (xi) return x;
      if (yi) return y;
    end
`endif
    if (x[30:0] >= y[30:0]) begin l = x; s = y; end
    else begin l = y; s = x; end
    el = int'(l[30:23]);
    es = int'(s[30:23]);
    ml = (el == 0) ? 0 : (longint'(l[22:0]) + 64'h80_0000);
    ms = (es == 0) ? 0 : (longint'(s[22:0]) + 64'h80_0000);
    dd = el - es;
    ms = (dd >= 24) ? 0 : (ms >> dd);
    sum = (l[31] == s[31]) ? ml + ms : ml - ms;
    if (sum == 0) return 32'h0;
    e  = el;
    sg = l[31];
    if (sum >= 64'h100_0000) begin
      sum = sum >> 1;
      e++;
    end else begin
      while (sum < 64'h80_0000) begin
        sum = sum << 1;
        e--;
      end
    end
    if (e <= 0)   return {sg, 31'b0};
    if (e >= 255) return {sg, 8'hFF, 23'b0};
    return {sg, 8'(e), 23'(sum)};
  endfunction

  function automatic logic [31:0] rnd_fp(input logic [31:0] near_v, input bit near);
    int          e;
    logic [22:0] f;
    if (near) begin
      e = int'(near_v[30:23]) + int'($urandom_range(0, 6)) - 3;
      if (e < 0)   e = 0;
      if (e > 254) e = 254;
      f = near_v[22:0] ^ (23'($urandom) >> $urandom_range(0, 22));
    end else begin
      e = (($urandom_range(0, 15)) == 0) ? 0 : int'($urandom_range(1, 254));
      f = 23'($urandom);
    end
    return {1'($urandom), 8'(e), f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop, input logic [31:0] ev);
    int unsigned g = 0;
    while (!in_ready && g < 60) begin
      tick();
      g++;
    end
    if (!in_ready) begin
      chk("issue_wait_in_ready", {31'b0, in_ready}, 32'd1);
      return;
    end
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    sb.push_back(ev);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned g = 0;
    while (sb.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) chk("scoreboard_nonempty", 32'd0, 32'd1);
      else begin
        exp_v = sb.pop_front();
        chk("result", result, exp_v);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached with %0d pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cnt;
    logic [31:0] av, bv;
    logic        ov;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_result", result, 32'h0);
    rst_n = 1'b1;
    tick();

    // latency: count rising edges from the accept edge (inclusive) to out_valid
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("latency", cnt, 32'd4);
    chk("busy_in_done", {31'b0, busy}, 32'd1);

    issue(32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
    issue(32'h3F80_0000, 32'h3080_0000, 1'b0, 32'h3F80_0000);
    issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
`ifdef FP_SPECIALS_EN
    issue(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
    issue(32'h7FC0_1234, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
    issue(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);
    issue(32'hFF80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000);
`endif
    drain();

    // backpressure: hold DONE for 10 cycles while a second request is offered
    out_ready = 1'b0;
    issue(32'h3FC0_0000, 32'h3FA0_0000, 1'b1, 32'h3E80_0000);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("stall_reach_done", {31'b0, out_valid}, 32'd1);
    a = 32'h4120_0000; b = 32'h4120_0000; op = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_result", result, 32'h3E80_0000);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("release_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (6) tick();
    chk("ignored_busy", {31'b0, busy}, 32'd0);
    chk("ignored_no_output", 32'(sb.size()), 32'd0);

    // asynchronous reset while in ADD
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
    tick();
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_result", result, 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    issue(32'h4000_0000, 32'h4040_0000, 1'b0, 32'h40A0_0000);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      av = rnd_fp(32'h0, 1'b0);
      bv = ($urandom_range(0, 1) == 1) ? rnd_fp(av, 1'b1) : rnd_fp(av, 1'b0);
      ov = 1'($urandom);
      issue(av, bv, ov, ref_add(av, bv, ov));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    rand_rdy = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
